uart_mmio: RTL and testbench

//   CPU-facing memory-mapped front end for the UART pair. It buffers outgoing bytes in a TX FIFO and

---
 rtl/uart_mmio_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_mmio.sv | 169 ++++++++++++++++
 tb/tb_uart_mmio.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and TX drain state encoding for the uart_mmio block.
package uart_mmio_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_OVERRUN  = 4;
  localparam int STAT_TX_IDLE  = 5;

  localparam int CTRL_CLR_OVR   = 0;
  localparam int CTRL_FLUSH_TX  = 1;
  localparam int CTRL_FLUSH_RX  = 2;
  localparam int CTRL_RX_IRQ_EN = 8;
  localparam int CTRL_TX_IRQ_EN = 9;

  typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_WAIT} tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is accepted only alongside a pop.
module uart_fifo
  import uart_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX/RX FIFOs, register decode and TX drain FSM.
// Optional interrupt logic is built only when UART_MMIO_IRQ_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_we,
  output logic [7:0]  uart_tx_buf,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_buf,
  input  logic        uart_rx_valid,
  output logic        irq
);

  logic [1:0]  sel;
  logic        wr_data, wr_ctrl, rd_data;
  logic        flush_tx, flush_rx, clr_ovr;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic        rx_valid_q, rx_push;
  logic        overrun;
  logic        tx_launch, tx_guard;
  tx_state_t   state, state_next;
  logic [5:0]  stat;
  logic [31:0] rdata_next;
  logic        unused_bits;

  assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata[31:8]};

  assign sel      = bus_addr[3:2];
  assign wr_data  = bus_we && (sel == REG_DATA);
  assign wr_ctrl  = bus_we && (sel == REG_CTRL);
  assign rd_data  = bus_re && (sel == REG_DATA);
  assign flush_tx = wr_ctrl && bus_wdata[CTRL_FLUSH_TX];
  assign flush_rx = wr_ctrl && bus_wdata[CTRL_FLUSH_RX];
  assign clr_ovr  = wr_ctrl && bus_wdata[CTRL_CLR_OVR];
  assign rx_push  = uart_rx_valid && !rx_valid_q;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (tx_launch),
    .flush (flush_tx),
    .din   (bus_wdata[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rd_data),
    .flush (flush_rx),
    .din   (uart_rx_buf),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  // A push into a full FIFO with a simultaneous pop is not an overrun; a new event beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid_q <= uart_rx_valid;
      if (rx_push && rx_full && !rd_data && !flush_rx) overrun <= 1'b1;
      else if (clr_ovr)                                overrun <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    tx_launch  = 1'b0;
    uart_we    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty && !uart_tx_busy && !flush_tx) begin
          tx_launch  = 1'b1;
          state_next = TX_ISSUE;
        end
      end
      TX_ISSUE: begin
        uart_we    = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        // First WAIT cycle is skipped so a busy flag that rises a cycle late is still seen.
        if (!tx_guard && !uart_tx_busy) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= TX_IDLE;
      tx_guard    <= 1'b0;
      uart_tx_buf <= 8'h00;
    end else begin
      state    <= state_next;
      tx_guard <= (state == TX_ISSUE);
      if (tx_launch) uart_tx_buf <= tx_head;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic rx_irq_en, tx_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_irq_en <= bus_wdata[CTRL_RX_IRQ_EN];
        tx_irq_en <= bus_wdata[CTRL_TX_IRQ_EN];
      end
      irq <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty && !uart_tx_busy) || overrun;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    stat                = '0;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_RX_EMPTY] = rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_OVERRUN]  = overrun;
    stat[STAT_TX_IDLE]  = tx_empty && !uart_tx_busy && !uart_we;
  end

  always_comb begin
    rdata_next = '0;
    case (sel)
      REG_DATA: if (!rx_empty) rdata_next = {23'b0, 1'b1, rx_head};
      REG_STAT: rdata_next = {26'b0, stat};
      REG_CTRL: begin
`ifdef UART_MMIO_IRQ_EN
        rdata_next[CTRL_RX_IRQ_EN] = rx_irq_en;
        rdata_next[CTRL_TX_IRQ_EN] = tx_irq_en;
`endif
      end
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       bus_rdata <= '0;
    else if (bus_re) bus_rdata <= rdata_next;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio with a simple uart transmitter model.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bus_addr;
  logic        bus_we, bus_re;
  logic [31:0] bus_wdata, bus_rdata;
  logic        uart_we;
  logic [7:0]  uart_tx_buf;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_buf;
  logic        uart_rx_valid;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  int          busy_cnt;
  logic        busy_force;
  logic [7:0]  cap_q[$];
  logic [31:0] rd;

  uart_mmio dut (
    .clk           (clk),
    .reset         (reset),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_re        (bus_re),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .uart_we       (uart_we),
    .uart_tx_buf   (uart_tx_buf),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_buf   (uart_rx_buf),
    .uart_rx_valid (uart_rx_valid),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 10 cycles after each accepted byte.
  assign uart_tx_busy = busy_force | (busy_cnt != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (uart_we) begin
      checks++;
      if (uart_tx_busy) begin
        errors++;
        $display("FAIL we_while_busy: uart_we=1 with uart_tx_busy=1, required no pulse");
      end
      cap_q.push_back(uart_tx_buf);
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_buf   = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    busy_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_rdata !== 32'h0 || uart_we !== 1'b0 || uart_tx_buf !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h we=%b tx_buf=%h irq=%b, required 0/0/0/0",
               bus_rdata, uart_we, uart_tx_buf, irq);
    end
    reset = 1'b0;
    @(negedge clk);
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h26) begin errors++; $display("FAIL reset_stat: got %h, required %h", rd, 32'h26); end
    bus_read(4'h8, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", rd); end
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", rd); end
  endtask

  task automatic test_tx_order;
    int n;
    do_reset();
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    bus_write(4'h0, 32'h43);
    n = 0;
    while (cap_q.size() < 3 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    checks++;
    if (cap_q.size() != 3) begin
      errors++;
      $display("FAIL tx_order_count: got %0d pulses, required 3", cap_q.size());
    end else begin
      checks++;
      if (cap_q[0] !== 8'h41 || cap_q[1] !== 8'h42 || cap_q[2] !== 8'h43) begin
        errors++;
        $display("FAIL tx_order_bytes: got %h %h %h, required 41 42 43", cap_q[0], cap_q[1], cap_q[2]);
      end
    end
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h26) begin errors++; $display("FAIL tx_order_stat: got %h, required %h", rd, 32'h26); end
  endtask

  task automatic test_tx_full;
    int n, bad;
    do_reset();
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) bus_write(4'h0, 32'(i));
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h05) begin errors++; $display("FAIL tx_full_stat: got %h, required %h", rd, 32'h05); end
    bus_write(4'h0, 32'hEE);
    busy_force = 1'b0;
    n = 0;
    while (cap_q.size() < 16 && n < 400) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    checks++;
    if (cap_q.size() != 16) begin
      errors++;
      $display("FAIL tx_full_count: got %0d bytes, required 16", cap_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (cap_q[i] !== 8'(i)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL tx_full_order: %0d bytes out of order, required 0", bad); end
    end
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h26) begin errors++; $display("FAIL tx_full_drained: got %h, required %h", rd, 32'h26); end
  endtask

  task automatic test_rx_level;
    do_reset();
    uart_rx_buf   = 8'h5A;
    uart_rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h15A) begin errors++; $display("FAIL rx_level_first: got %h, required %h", rd, 32'h15A); end
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rx_level_second: got %h, required 0", rd); end
    checks++;
    if (irq !== 1'b0 && 0 == 0) begin
`ifndef UART_MMIO_IRQ_EN
      errors++;
      $display("FAIL irq_tied: got %b, required 0", irq);
`endif
    end
  endtask

  task automatic test_rx_overrun;
    do_reset();
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i));
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h3A) begin errors++; $display("FAIL ovr_stat: got %h, required %h", rd, 32'h3A); end
    bus_write(4'h8, 32'h1);
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h2A) begin errors++; $display("FAIL ovr_clear: got %h, required %h", rd, 32'h2A); end
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h0, rd);
      checks++;
      if (rd !== 32'h180 + 32'(i)) begin
        errors++;
        $display("FAIL ovr_data%0d: got %h, required %h", i, rd, 32'h180 + 32'(i));
      end
    end
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ovr_byte17: got %h, required 0", rd); end
  endtask

  task automatic test_rx_full_pop;
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h10 + i));
    bus_addr      = 4'h0;
    bus_re        = 1'b1;
    uart_rx_buf   = 8'h99;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    bus_re        = 1'b0;
    uart_rx_valid = 1'b0;
    rd            = bus_rdata;
    checks++;
    if (rd !== 32'h110) begin errors++; $display("FAIL full_pop_read: got %h, required %h", rd, 32'h110); end
    @(negedge clk);
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h2A) begin errors++; $display("FAIL full_pop_stat: got %h, required %h", rd, 32'h2A); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'h111 + 32'(i) : 32'h199;
      bus_read(4'h0, rd);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL full_pop_data%0d: got %h, required %h", i, rd, exp); end
    end
  endtask

  task automatic test_ctrl_flush;
    do_reset();
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(4'h0, 32'hA0 + 32'(i));
    bus_write(4'h8, 32'h2);
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h06) begin errors++; $display("FAIL flush_tx_stat: got %h, required %h", rd, 32'h06); end
    busy_force = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL flush_tx_sent: got %0d bytes, required 0", cap_q.size()); end
    rx_byte(8'h11);
    rx_byte(8'h22);
    bus_write(4'h8, 32'h4);
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h26) begin errors++; $display("FAIL flush_rx_stat: got %h, required %h", rd, 32'h26); end
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reserved: got %h, required 0", rd); end
    bus_write(4'h8, 32'h300);
    bus_read(4'h8, rd);
    checks++;
`ifdef UART_MMIO_IRQ_EN
    if (rd !== 32'h300) begin errors++; $display("FAIL ctrl_read: got %h, required %h", rd, 32'h300); end
`else
    if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h, required 0", rd); end
`endif
  endtask

`ifdef UART_MMIO_IRQ_EN
  task automatic test_irq;
    do_reset();
    bus_write(4'h8, 32'h100);
    rx_byte(8'h33);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b, required 1", irq); end
    bus_read(4'h0, rd);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(4'h0, 32'hC0 + 32'(i));
    n = 0;
    while (uart_we !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (uart_we !== 1'b1) begin errors++; $display("FAIL mid_issue_seen: got we=%b, required 1", uart_we); end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (uart_we !== 1'b0) begin errors++; $display("FAIL mid_wait_we: got %b, required 0", uart_we); end
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    bus_read(4'h4, rd);
    checks++;
    if ((rd & 32'h1F) !== 32'h06 || rd[5] !== 1'b1) begin
      errors++;
      $display("FAIL mid_stat: got %h, required %h", rd, 32'h26);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (cap_q.size() != 0) begin errors++; $display("FAIL mid_no_tx: got %0d bytes, required 0", cap_q.size()); end
    bus_write(4'h0, 32'h77);
    n = 0;
    while (uart_we !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (uart_we !== 1'b0 || uart_tx_buf !== 8'h00) begin
      errors++;
      $display("FAIL mid_issue_reset: we=%b tx_buf=%h, required 0/00", uart_we, uart_tx_buf);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    bus_addr      = 4'h0;
    bus_we        = 1'b0;
    bus_re        = 1'b0;
    bus_wdata     = 32'h0;
    busy_force    = 1'b0;
    uart_rx_buf   = 8'h00;
    uart_rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_level();
    test_rx_overrun();
    test_rx_full_pop();
    test_ctrl_flush();
`ifdef UART_MMIO_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
